// File: rtl/serial_subtractor_if.sv
// ============================================================================
//  Module   : serial_subtractor_if
//  Brief    : Operand/result handshake bundle for the bit-serial subtractor.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface serial_subtractor_if #(
    parameter int DATA_WIDTH = 4
);
    logic [DATA_WIDTH-1:0] a;
    logic [DATA_WIDTH-1:0] b;
    logic                  bi;
    logic                  in_vld;
    logic                  in_rd;
    logic [DATA_WIDTH-1:0] d;
    logic                  bo;
    logic                  out_vld;
    logic                  out_rd;

    modport master (
        output a, b, bi, in_vld, out_rd,
        input  in_rd, d, bo, out_vld
    );

    modport slave (
        input  a, b, bi, in_vld, out_rd,
        output in_rd, d, bo, out_vld
    );
endinterface

`default_nettype wire

// File: rtl/serial_subtractor.sv
// ============================================================================
//  Module   : serial_subtractor
//  Brief    : Bit-serial ripple-borrow subtractor, d = a - b - bi, LSB first.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module serial_subtractor #(
    parameter int DATA_WIDTH = 4
) (
    input  logic                clk,
    input  logic                rst,
    serial_subtractor_if.slave  bus
);

    localparam int CNT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DATA_WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t                state;
    state_t                state_next;
    logic [CNT_W-1:0]      cnt;
    logic [DATA_WIDTH-1:0] a_sh;
    logic [DATA_WIDTH-1:0] b_sh;
    logic [DATA_WIDTH-1:0] res_sh;
    logic                  borrow;
    logic [DATA_WIDTH-1:0] d_reg;
    logic                  bo_reg;

    logic                  accept;
    logic                  release_out;
    logic                  last_bit;
    logic                  bit_a;
    logic                  bit_b;
    logic                  diff_bit;
    logic                  borrow_next;
    logic [DATA_WIDTH-1:0] res_next;
    logic                  in_rd_int;
    logic                  out_vld_int;

    // ------------------------------------------------------------------
    // Control FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next  = state;
        in_rd_int   = 1'b0;
        out_vld_int = 1'b0;
        accept      = 1'b0;
        release_out = 1'b0;
        last_bit    = (cnt == LAST_CNT);
        case (state)
            IDLE: begin
                in_rd_int = ~rst;
                accept    = bus.in_vld & ~rst;
                if (accept) begin
                    state_next = RUN;
                end
            end
            RUN: begin
                if (last_bit) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                out_vld_int = 1'b1;
                release_out = bus.out_rd;
                if (release_out) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Full-subtractor cell, iterated over the operand bits
    // ------------------------------------------------------------------
    always_comb begin
        bit_a       = a_sh[0];
        bit_b       = b_sh[0];
        diff_bit    = bit_a ^ bit_b ^ borrow;
        borrow_next = (~bit_a & bit_b) | (~(bit_a ^ bit_b) & borrow);
        // New difference bit enters at the MSB so the LSB lands at bit 0 last.
        res_next    = (res_sh >> 1) | (DATA_WIDTH'(diff_bit) << (DATA_WIDTH - 1));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt    <= '0;
            a_sh   <= '0;
            b_sh   <= '0;
            res_sh <= '0;
            borrow <= 1'b0;
            d_reg  <= '0;
            bo_reg <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        a_sh   <= bus.a;
                        b_sh   <= bus.b;
                        borrow <= bus.bi;
                        cnt    <= '0;
                    end
                end
                RUN: begin
                    a_sh   <= a_sh >> 1;
                    b_sh   <= b_sh >> 1;
                    res_sh <= res_next;
                    borrow <= borrow_next;
                    cnt    <= cnt + 1'b1;
                    // The published result only changes once the word is complete.
                    if (last_bit) begin
                        d_reg  <= res_next;
                        bo_reg <= borrow_next;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign bus.in_rd   = in_rd_int;
    assign bus.out_vld = out_vld_int;
    assign bus.d       = d_reg;
    assign bus.bo      = bo_reg;

endmodule

`default_nettype wire
